rr3_arbiter_atc: RTL and testbench
==================================

// Module: rr3_arbiter_atc
// PURPOSE
//  Three-way round-robin arbiter with access time control for processors A, B and C sharing one bus.
//  Grants one requester at a time. Each grant lasts at most a programmable number of cycles (access time).
//  Rotates priority A->B->C->A. This is the DUT sequenced by the arbiter BFM command set (NOREQ..SACC).
// PARAMETERS
//  ATW     4    width of access-time register/timer
//  AT_RST  4    access time loaded at reset (cycles, 1..2**ATW-1)
// PORTS
//  clk       in   1    single clock, all logic on posedge
//  reset     in   1    synchronous, active-high reset
//  req_a     in   1    request from processor A (level, held until done)
//  req_b     in   1    request from processor B
//  req_c     in   1    request from processor C
//  at_load   in   1    1-cycle strobe: capture at_value as new access time
//  at_value  in   ATW  access time in cycles; 0 is treated as 1
//  gnt_a     out  1    grant to A (registered, one-hot with gnt_b/gnt_c)
//  gnt_b     out  1    grant to B
//  gnt_c     out  1    grant to C
//  busy      out  1    any grant active (OR of grants)
//  at_cur    out  ATW  current access-time register value
// BEHAVIOUR
//  Reset: state IDLE, gnt_* = 0, busy = 0, at_cur = AT_RST, timer = 0, rr pointer = A.
//  FSM states: IDLE, GNTA, GNTB, GNTC. Grants are decoded from registered state.
//  Latency: request sampled at edge N; grant visible after edge N (1 cycle).
//  IDLE: pick the first active request starting from the rr pointer. Load timer = at_cur; go GNTx.
//   With no request, stay IDLE.
//  GNTx, each cycle: timer decrements. Release occurs when req_x is low or timer reaches 1 (expiry).
//   Max grant = at_cur cycles.
//  On release: rr pointer = successor of x. In the same edge, select the next requester
//   from the new pointer, excluding x if its req is low. No idle bubble between grants.
//  Expiry with x the only requester: x is re-granted with timer reloaded (gnt_x stays high).
//  Expiry with others pending: gnt_x drops and the next in rotation rises on the same edge.
//  Simultaneous A+B+C from IDLE after reset: order A, B, C, A...
//  at_load: at_cur updates on the next edge. A grant in progress keeps its loaded timer.
//   The new value applies from the next grant start. at_load with at_value = 0 stores 1.
//  at_load coincident with grant start: the grant uses the old at_cur.
//  reset mid-grant: all grants drop on the reset edge; at_cur returns to AT_RST.
//  Requests arriving during a grant never preempt it.
// CONFIGURATION
//  ARB_GNT_CNT_EN defined: adds outputs cnt_a, cnt_b, cnt_c (8 bits each).
//   Each is a saturating count of grant starts (re-grants included) per requester.
//   Cleared by reset; saturates at 8'hFF.
//  Not defined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package arb_pkg: state encoding localparams (IDLE=2'd0, GNTA=2'd1, GNTB=2'd2, GNTC=2'd3).
//   Also holds rr-pointer encoding and the AT_RST default.
//  Sub-module rr3_pick: combinational 3-way round-robin select (req[2:0], ptr -> one-hot/valid).
//  Timer, at_cur register and optional counters stay in the top module.
// TESTING
//  NOREQ: reset, all req=0 for 10 cycles -> gnt_*=0, busy=0, at_cur=4.
//  REQFA: req_a=1 -> gnt_a=1 one cycle later. Held 4 cycles, then re-granted with no gap.
//   req_a=0 -> gnt_a=0 next cycle.
//  REQFB/REQFC: same as REQFA for B and C alone. Grant and release latencies are identical.
//  SACC: at_load with at_value=2, then req_b -> gnt_b high exactly 2 cycles per grant.
//   at_value=0 -> at_cur=1.
//  ATCAB/ATCBC/ATCCA: two reqs held, at_cur=3. Grants alternate every 3 cycles with no bubble.
//   ATCAB order: A,B. ATCBC order: B,C. ATCCA order: A,C after reset.
//  All three held, then reset asserted mid-GNTB -> grants 0 after the edge.
//   After reset deasserts, gnt_a first.
//   With ARB_GNT_CNT_EN, cnt_* = 0 after reset.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - state/pointer encodings and helpers for rr3_arbiter_atc (feature macro: ARB_GNT_CNT_EN)
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNTA = 2'd1,
        GNTB = 2'd2,
        GNTC = 2'd3
    } state_t;

    localparam logic [1:0] PTR_A = 2'd0;
    localparam logic [1:0] PTR_B = 2'd1;
    localparam logic [1:0] PTR_C = 2'd2;

    localparam int AT_RST_DEF = 4;

    function automatic logic [1:0] rr_succ(input logic [1:0] p);
        return (p == PTR_C) ? PTR_A : p + 2'd1;
    endfunction

    function automatic logic [1:0] state_ptr(input state_t s);
        case (s)
            GNTB:    return PTR_B;
            GNTC:    return PTR_C;
            default: return PTR_A;
        endcase
    endfunction

    function automatic state_t onehot_state(input logic [2:0] oh);
        case (oh)
            3'b001:  return GNTA;
            3'b010:  return GNTB;
            3'b100:  return GNTC;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr3_pick.sv
// rtl/rr3_pick.sv - combinational 3-way round-robin select starting at ptr
module rr3_pick
    import arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic       valid
);

    always_comb begin
        gnt   = 3'b000;
        valid = |req;
        case (ptr)
            PTR_B: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            PTR_C: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/rr3_arbiter_atc.sv
// rtl/rr3_arbiter_atc.sv - 3-way round-robin bus arbiter with access time control (optional ARB_GNT_CNT_EN grant counters)
module rr3_arbiter_atc
    import arb_pkg::*;
#(
    parameter int ATW    = 4,
    parameter int AT_RST = AT_RST_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_a,
    input  logic           req_b,
    input  logic           req_c,
    input  logic           at_load,
    input  logic [ATW-1:0] at_value,
    output logic           gnt_a,
    output logic           gnt_b,
    output logic           gnt_c,
    output logic           busy,
`ifdef ARB_GNT_CNT_EN
    output logic [7:0]     cnt_a,
    output logic [7:0]     cnt_b,
    output logic [7:0]     cnt_c,
`endif
    output logic [ATW-1:0] at_cur
);

    state_t         state, state_nxt;
    logic [1:0]     ptr, ptr_nxt, pick_ptr;
    logic [ATW-1:0] timer, timer_nxt;
    logic [2:0]     req_vec, gnt_vec, pick_gnt;
    logic           pick_valid, release_now, start;

    assign req_vec = {req_c, req_b, req_a};
    assign gnt_vec = {state == GNTC, state == GNTB, state == GNTA};

    // Release on dropped request or on the last cycle of the access window.
    assign release_now = (state != IDLE) &&
                         (((gnt_vec & req_vec) == 3'b000) || (timer == ATW'(1)));
    assign pick_ptr    = (state == IDLE) ? ptr : rr_succ(state_ptr(state));

    rr3_pick u_pick (
        .req   (req_vec),
        .ptr   (pick_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        timer_nxt = timer;
        start     = 1'b0;
        if (state == IDLE) begin
            start = pick_valid;
        end else if (release_now) begin
            ptr_nxt = pick_ptr;
            start   = pick_valid;
            if (!pick_valid) state_nxt = IDLE;
        end else begin
            timer_nxt = timer - ATW'(1);
        end
        if (start) begin
            state_nxt = onehot_state(pick_gnt);
            timer_nxt = at_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= PTR_A;
            timer  <= '0;
            at_cur <= ATW'(AT_RST);
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            timer <= timer_nxt;
            if (at_load) at_cur <= (at_value == '0) ? ATW'(1) : at_value;
        end
    end

    assign gnt_a = gnt_vec[0];
    assign gnt_b = gnt_vec[1];
    assign gnt_c = gnt_vec[2];
    assign busy  = |gnt_vec;

`ifdef ARB_GNT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
        end else if (start) begin
            if (pick_gnt[0] && cnt_a != 8'hFF) cnt_a <= cnt_a + 8'd1;
            if (pick_gnt[1] && cnt_b != 8'hFF) cnt_b <= cnt_b + 8'd1;
            if (pick_gnt[2] && cnt_c != 8'hFF) cnt_c <= cnt_c + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr3_arbiter_atc.sv
// tb/tb_rr3_arbiter_atc.sv - scoreboard bench for rr3_arbiter_atc (ARB_GNT_CNT_EN aware)
module tb_rr3_arbiter_atc;

    localparam int ATW = 4;

    logic           clk = 1'b0;
    logic           reset, req_a, req_b, req_c, at_load;
    logic [ATW-1:0] at_value;
    logic           gnt_a, gnt_b, gnt_c, busy;
    logic [ATW-1:0] at_cur;
`ifdef ARB_GNT_CNT_EN
    logic [7:0]     cnt_a, cnt_b, cnt_c;
`endif

    always #5 clk = ~clk;

    rr3_arbiter_atc #(.ATW(ATW), .AT_RST(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_c    (req_c),
        .at_load  (at_load),
        .at_value (at_value),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .gnt_c    (gnt_c),
        .busy     (busy),
`ifdef ARB_GNT_CNT_EN
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
`endif
        .at_cur   (at_cur)
    );

    typedef struct packed {
        logic [2:0]     gnt;
        logic           busy;
        logic [ATW-1:0] at;
        logic [23:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: owner 0 = none, 1..3 = A..C; left = grant cycles remaining.
    int m_owner, m_left, m_ptr, m_at;
    int m_cnt[3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int find_req(input logic [2:0] r, input int from);
        for (int i = 0; i < 3; i++)
            if (r[(from + i) % 3]) return (from + i) % 3;
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [2:0] r, input logic ld, input int v);
        int k, x;
        if (rst) begin
            m_owner = 0; m_left = 0; m_ptr = 0; m_at = 4;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            return;
        end
        k = -2;
        if (m_owner == 0) begin
            k = find_req(r, m_ptr);
        end else begin
            x = m_owner - 1;
            if (!r[x] || m_left == 1) begin
                m_ptr = (x + 1) % 3;
                k = find_req(r, m_ptr);
                if (k < 0) m_owner = 0;
            end else begin
                m_left--;
            end
        end
        if (k >= 0) begin
            m_owner = k + 1;
            m_left  = m_at;
            if (m_cnt[k] < 255) m_cnt[k]++;
        end
        if (ld) m_at = (v == 0) ? 1 : v;
    endtask

    task automatic cycle(input logic rst, input logic [2:0] r, input logic ld = 1'b0, input int v = 0);
        exp_t e, o;
        @(negedge clk);
        reset = rst; {req_c, req_b, req_a} = r; at_load = ld; at_value = ATW'(v);
        model_step(rst, r, ld, v);
        e.gnt  = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
        e.busy = (m_owner != 0);
        e.at   = ATW'(m_at);
        e.cnt  = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check_val("sb_gnt", {29'd0, gnt_c, gnt_b, gnt_a}, {29'd0, o.gnt});
        check_val("sb_busy", {31'd0, busy}, {31'd0, o.busy});
        check_val("sb_at_cur", 32'(at_cur), 32'(o.at));
`ifdef ARB_GNT_CNT_EN
        check_val("sb_cnt", {8'd0, cnt_c, cnt_b, cnt_a}, {8'd0, o.cnt});
`endif
    endtask

    logic [2:0] seq [12];
    logic [2:0] rnd;
    logic [2:0] one;
    logic [2:0] pair;

    initial begin
        reset = 1'b1; {req_c, req_b, req_a} = 3'b000; at_load = 1'b0; at_value = '0;
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        check_val("rst_gnt", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd0);
        check_val("rst_at_cur", 32'(at_cur), 32'd4);
`ifdef ARB_GNT_CNT_EN
        check_val("rst_cnt", {8'd0, cnt_c, cnt_b, cnt_a}, 32'd0);
`endif

        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b000);
        check_val("noreq_busy", {31'd0, busy}, 32'd0);

        // Single requester: grant one edge after request, held across re-grants, drop one edge after release.
        for (int n = 0; n < 3; n++) begin
            one = 3'(1 << n);
            cycle(1'b0, one);
            check_val("single_first", {29'd0, gnt_c, gnt_b, gnt_a}, 32'(one));
            for (int i = 0; i < 9; i++) cycle(1'b0, one);
            check_val("single_held", {29'd0, gnt_c, gnt_b, gnt_a}, 32'(one));
            cycle(1'b0, 3'b000);
            check_val("single_drop", {31'd0, busy}, 32'd0);
        end

        cycle(1'b0, 3'b000, 1'b1, 2);
        check_val("sacc_at2", 32'(at_cur), 32'd2);
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'b010);
        cycle(1'b0, 3'b000, 1'b1, 0);
        check_val("sacc_at0", 32'(at_cur), 32'd1);

        // Two requesters held with access time 3: expected order from a fresh reset.
        for (int p = 0; p < 3; p++) begin
            pair = (p == 0) ? 3'b011 : (p == 1) ? 3'b110 : 3'b101;
            cycle(1'b1, 3'b000);
            cycle(1'b0, 3'b000, 1'b1, 3);
            for (int i = 0; i < 12; i++) begin
                cycle(1'b0, pair);
                seq[i] = {gnt_c, gnt_b, gnt_a};
            end
            check_val("pair_first", 32'(seq[0]), (p == 1) ? 32'd2 : 32'd1);
            check_val("pair_third", 32'(seq[2]), 32'(seq[0]));
            check_val("pair_second", 32'(seq[3]), (p == 0) ? 32'd2 : 32'd4);
            check_val("pair_back", 32'(seq[6]), 32'(seq[0]));
        end

        // Access time change mid-grant and coincident with a grant start.
        cycle(1'b1, 3'b000);
        cycle(1'b0, 3'b001, 1'b1, 3);
        cycle(1'b0, 3'b001);
        cycle(1'b0, 3'b001, 1'b1, 5);
        for (int i = 0; i < 12; i++) cycle(1'b0, 3'b011);

        // All three held, reset during B's grant, then A first again.
        cycle(1'b1, 3'b000);
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'b111);
        check_val("all_in_b", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd2);
        cycle(1'b1, 3'b111);
        check_val("mid_rst_gnt", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd0);
        check_val("mid_rst_at", 32'(at_cur), 32'd4);
        cycle(1'b0, 3'b111);
        check_val("after_rst_a", {29'd0, gnt_c, gnt_b, gnt_a}, 32'd1);

        rnd = 3'b000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(7) == 0) rnd[b] = ~rnd[b];
            cycle(($urandom_range(99) == 0), rnd, ($urandom_range(15) == 0), $urandom_range(15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
